// File: rtl/tick_divider_bank.sv
// tick_divider_bank: bank of programmable clock-enable (tick) generators with shadowed divisors.
// Define SQUARE_OUT_EN to implement the per-channel square-wave outputs (sq); otherwise sq is tied low.
module tick_divider_bank #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 27,
    parameter int DEF_DIV = 40000000,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] cfg_pend,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cfg_err <= 1'b0;
        else cfg_err <= cfg_we && (int'(cfg_ch) >= NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt, div, shadow;
        logic wr, run, wrap, apply, t, p;
        assign wr    = cfg_we && (int'(cfg_ch) == i);
        assign run   = en && (div != '0);
        assign wrap  = run && (cnt == div - CNT_W'(1));
        // a disabled channel never wraps, so a pending divisor is taken on the next edge
        assign apply = p && ((div == '0) || wrap);
        assign tick[i]     = t;
        assign cfg_pend[i] = p;

        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                cnt    <= '0;
                div    <= CNT_W'(DEF_DIV);
                shadow <= CNT_W'(DEF_DIV);
                t      <= 1'b0;
                p      <= 1'b0;
            end else begin
                cnt <= (sync_clr || wrap) ? '0 : (run ? cnt + CNT_W'(1) : cnt);
                t   <= !sync_clr && wrap;
                if (sync_clr ? p : apply) div <= shadow;
                if (wr) shadow <= cfg_div;
                p   <= wr || (p && !(sync_clr || apply));
            end

`ifdef SQUARE_OUT_EN
        logic s;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) s <= 1'b0;
            else if (sync_clr) s <= 1'b0;
            else if (wrap) s <= ~s;
        assign sq[i] = s;
`else
        assign sq[i] = 1'b0;
`endif
    end
endmodule

// File: doc/tick_divider_bank.md
Name: tick_divider_bank

Overview:
- Parametrised bank of NUM_CH independent clock-enable generators, all running from the single system clock.
- Each channel emits a one-cycle tick every DIV clocks and, optionally, a square-wave toggle output.
- Replaces per-rate free-running toggled clocks; downstream logic (display mux, light FSM timers) stays on clk and qualifies with tick.
- Divisors are runtime-programmable, with glitch-free reload at the channel's wrap point.

Parameters:
- NUM_CH, 4: number of channels.
- CNT_W, 27: counter and divisor width in bits.
- DEF_DIV, 40000000: divisor loaded into every channel at reset. Must fit in CNT_W.
- CH_W, max(1, ceil(log2(NUM_CH))): channel-select width. Derived; not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- en  in  1  global run; low freezes all counters.
- sync_clr  in  1  synchronous restart of all channels, phase-aligned.
- cfg_we  in  1  divisor write strobe, single cycle.
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  CNT_W  new divisor; 0 disables the channel.
- cfg_err  out  1  one-cycle pulse when cfg_we targets cfg_ch >= NUM_CH.
- cfg_pend  out  NUM_CH  per-channel flag: a written divisor is waiting to be applied.
- tick  out  NUM_CH  one-cycle enable pulse per channel.
- sq  out  NUM_CH  square output per channel; toggles on each tick.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - cnt = 0, active div = DEF_DIV, shadow = DEF_DIV.
  - cfg_pend = 0, tick = 0, sq = 0, cfg_err = 0.
  - All outputs are registered.
- Per-channel counting (en=1, sync_clr=0, div>=1):
  - If cnt == div-1: cnt <= 0 and tick <= 1 (visible the next cycle); otherwise cnt <= cnt+1 and tick <= 0.
  - Tick period = div clocks. First tick is high after the div-th enabled edge following reset.
  - div = 1: tick is high every cycle; sq toggles every cycle.
- sq toggles on every edge that sets tick, giving period 2*div clocks with 50% duty.
- Disabled channel (div == 0): cnt held at 0, tick = 0, sq holds its value.
- en = 0: all cnt and sq hold, tick forced 0. Configuration writes are still accepted.
- sync_clr = 1 (priority over en):
  - All cnt <= 0, tick <= 0, sq <= 0.
  - Any pending shadow is applied and cfg_pend cleared.
- Configuration:
  - cfg_we with valid cfg_ch: shadow[ch] <= cfg_div, cfg_pend[ch] <= 1.
  - The shadow is applied (div <= shadow, cfg_pend <= 0) at the channel's next wrap edge, or on the next edge if the current div == 0.
- Same-cycle write and wrap on the same channel: the wrap applies the old shadow; the new value is stored in the shadow and cfg_pend stays 1. No write is lost.
- Repeated writes before application: the last write wins.
- Invalid cfg_ch: no state change; cfg_err pulses for exactly one cycle.
- Arithmetic: counters are unsigned CNT_W. Comparison uses div-1 computed in CNT_W; it is never evaluated when div == 0.
- Reset mid-count: all state returns to reset values immediately; no tick is emitted while rst_n is low.

Optional Feature:
- Macro: SQUARE_OUT_EN.
- Defined: sq toggle flops are implemented as specified above.
- Undefined: sq is tied to 0 and its flops are removed. tick behaviour is unchanged.

Test Plan:
All scenarios use NUM_CH=2, CNT_W=8, DEF_DIV=4, SQUARE_OUT_EN defined.
- Reset release with en=1 -> tick[0] and tick[1] high in cycles 4, 8, 12 after release; sq toggles 0->1 at cycle 4 and 1->0 at cycle 8.
- Write cfg_ch=1, cfg_div=2 at cycle 2 -> cfg_pend[1]=1 until the wrap at cycle 4; then tick[1] at 6, 8, 10; channel 0 is unaffected.
- en low for cycles 5-9 mid-count -> no ticks and cnt frozen; the schedule resumes shifted by 5 cycles; sq holds.
- cfg_div=0 to ch0, then cfg_div=3 -> ch0 goes silent after its wrap; the second write applies on the next edge; ticks resume every 3 cycles.
- sync_clr pulsed with ch1 pending -> both cnt=0, sq=0, cfg_pend=0; the first ticks land div cycles later on both channels simultaneously when their divs are equal.
- cfg_we with cfg_ch=1 where NUM_CH=1 (rebuild), and rst_n dropped mid-count -> cfg_err pulses one cycle with no state change; all outputs go 0 asynchronously.
